// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard controller for the rv32i 5-stage core. Decodes
//             the instruction in ID against the EX stage and drives the PC /
//             IF-ID enables and the bubble flushes.
//             - load-use hazards stall for LOAD_USE_CYCLES cycles
//             - control-flow instrs (BRANCH/JAL/JALR) block fetch for up to
//               CTRL_PENALTY cycles, released early by ex_ctrl_resolved
//             A saturating counter tallies cycles with pc_enable low.
//  Ports    : clk, rst_n (async, active-low)
//             id_instr[31:0], id_valid       instruction in ID
//             ex_is_load, ex_rd[4:0]         load / destination in EX
//             ex_ctrl_resolved               control instr in EX resolved
//             pc_enable, ifid_enable         stage enables
//             ifid_flush, idex_flush         bubble inserts
//             stall_count[CNT_W-1:0]         saturating stall-cycle counter
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CTRL_PENALTY    = 2,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_ctrl_resolved,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MAX_P = (CTRL_PENALTY > LOAD_USE_CYCLES) ? CTRL_PENALTY : LOAD_USE_CYCLES;
    localparam int CW    = $clog2(MAX_P + 1);

    // The detect cycle is spent in RUN, so the wait states only cover the rest.
    localparam logic [CW-1:0] LU_RELOAD   = CW'(LOAD_USE_CYCLES - 1);
    localparam logic [CW-1:0] CTRL_RELOAD = CW'(CTRL_PENALTY - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        CTRL_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       is_ctrl, uses_rs1, uses_rs2, lu_hz;
    logic       unused_instr_bits;

    assign opcode   = id_instr[6:0];
    assign rs1      = id_instr[19:15];
    assign rs2      = id_instr[24:20];

    assign is_ctrl  = id_valid && ((opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR));
    assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    assign uses_rs2 = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_OP);

    // x0 is never a real dependency, even when a load targets it.
    assign lu_hz    = id_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

    assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:7]};

    // ------------------------------------------------------------------
    // Next state and outputs (Mealy in RUN so the hazard is acted on in
    // the very cycle it is seen in ID)
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_enable   = 1'b1;
        ifid_enable = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;

        case (state_q)
            RUN: begin
                if (lu_hz) begin
                    pc_enable   = 1'b0;
                    ifid_enable = 1'b0;
                    idex_flush  = 1'b1;
                    if (LOAD_USE_CYCLES > 1) begin
                        state_d = LU_STALL;
                        cnt_d   = LU_RELOAD;
                    end
                end else if (is_ctrl) begin
                    // Control instr moves on to EX; fetch is blocked behind it.
                    pc_enable  = 1'b0;
                    ifid_flush = 1'b1;
                    if (CTRL_PENALTY > 1) begin
                        state_d = CTRL_WAIT;
                        cnt_d   = CTRL_RELOAD;
                    end
                end
            end
            LU_STALL: begin
                pc_enable   = 1'b0;
                ifid_enable = 1'b0;
                idex_flush  = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            CTRL_WAIT: begin
                // Resolution only ends the wait from the following cycle on.
                pc_enable  = 1'b0;
                ifid_flush = 1'b1;
                if ((cnt_q == CNT_ONE) || ex_ctrl_resolved) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        // Outputs must show pass-through the instant reset asserts, before
        // the flops have been observed by any edge.
        if (!rst_n) begin
            pc_enable   = 1'b1;
            ifid_enable = 1'b1;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_enable && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
`default_nettype wire
